// File: rtl/fast_scan_pkg.sv
// Shared types for the corner-detection raster sequencer: FSM states,
// window byte lanes and the keypoint record carried through the FIFO.
package fast_scan_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam int LANE_W   = 8;
    localparam int LANE_OLD = 0;
    localparam int LANE_CTR = 8;
    localparam int LANE_NEW = 16;

    // Record fields are sized for the largest supported frame (1024x512).
    localparam int KP_X_W = 10;
    localparam int KP_Y_W = 9;

    typedef struct packed {
        logic [KP_X_W-1:0] x;
        logic [KP_Y_W-1:0] y;
    } kp_rec_t;

    function automatic logic [23:0] shift_in(input logic [23:0] row, input logic [7:0] pix);
        logic [23:0] r;
        r[LANE_OLD +: LANE_W] = row[LANE_CTR +: LANE_W];
        r[LANE_CTR +: LANE_W] = row[LANE_NEW +: LANE_W];
        r[LANE_NEW +: LANE_W] = pix;
        return r;
    endfunction

endpackage

// File: rtl/fast_scan_ctrl_kp_fifo.sv
// First-word fall-through keypoint FIFO; head reads as zero while empty.
module kp_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 19,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok   = pop && (count != '0);
    assign push_ok  = push && ((count != (AW+1)'(DEPTH)) || pop_ok);
    assign pop_data = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fast_scan_ctrl.sv
// Raster-scan sequencer: line buffers, 3x3 window assembly for the external
// corner filter, and a keypoint coordinate FIFO for the descriptor stage.
//
//   state | meaning
//   IDLE  | waiting for start
//   SCAN  | accepting pixels of the current frame
//   DRAIN | last pixel taken; waiting for in-flight window and FIFO to empty
//   DONE  | one-cycle done pulse
module fast_scan_ctrl
    import fast_scan_pkg::*;
#(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int KP_DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           pix_valid,
    input  logic [7:0]     pix_data,
    output logic           pix_ready,
    output logic [23:0]    filter_input_0,
    output logic [23:0]    filter_input_1,
    output logic [23:0]    filter_input_2,
    input  logic           valid_keypoint,
    output logic           kp_valid,
    output logic [X_W-1:0] kp_x,
    output logic [Y_W-1:0] kp_y,
    input  logic           kp_ready,
    output logic           busy,
    output logic           done
);

    localparam int CW  = $clog2(KP_DEPTH) + 1;
    localparam int LBW = $clog2(IMG_W);

    state_t         state;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [LBW-1:0] lb_idx;
    logic [7:0]     lb_a [IMG_W];
    logic [7:0]     lb_b [IMG_W];
    logic [23:0]    win_0, win_1, win_2;
    logic           win_valid;
    logic [X_W-1:0] ctr_x;
    logic [Y_W-1:0] ctr_y;
    logic [CW-1:0]  kp_count;
    logic           accept;
    logic           push;
    logic           pop;
    kp_rec_t        push_rec;
    kp_rec_t        head_rec;

    // One slot stays free for the window that may already be in flight.
    assign pix_ready = (state == SCAN) && (kp_count <= CW'(KP_DEPTH - 2));
    assign accept    = pix_valid && pix_ready;
    assign push      = win_valid && valid_keypoint;
    assign kp_valid  = (kp_count != '0);
    assign pop       = kp_valid && kp_ready;
    assign lb_idx    = x[LBW-1:0];

    assign push_rec.x = KP_X_W'(ctr_x);
    assign push_rec.y = KP_Y_W'(ctr_y);
    assign kp_x       = X_W'(head_rec.x);
    assign kp_y       = Y_W'(head_rec.y);

    assign filter_input_0 = win_0;
    assign filter_input_1 = win_1;
    assign filter_input_2 = win_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            win_0     <= '0;
            win_1     <= '0;
            win_2     <= '0;
            win_valid <= 1'b0;
            ctr_x     <= '0;
            ctr_y     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done      <= 1'b0;
            win_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                        x     <= '0;
                        y     <= '0;
                        win_0 <= '0;
                        win_1 <= '0;
                        win_2 <= '0;
                    end
                end
                SCAN: begin
                    if (accept) begin
                        win_0     <= shift_in(win_0, lb_a[lb_idx]);
                        win_1     <= shift_in(win_1, lb_b[lb_idx]);
                        win_2     <= shift_in(win_2, pix_data);
                        // x>=2 also masks windows straddling a row wrap.
                        win_valid <= (x >= X_W'(2)) && (y >= Y_W'(2));
                        ctr_x     <= x - X_W'(1);
                        ctr_y     <= y - Y_W'(1);
                        if (x == X_W'(IMG_W - 1)) begin
                            x <= '0;
                            if (y == Y_W'(IMG_H - 1)) begin
                                y     <= '0;
                                state <= DRAIN;
                            end else begin
                                y <= y + Y_W'(1);
                            end
                        end else begin
                            x <= x + X_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!win_valid && (kp_count == '0)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb_a[lb_idx] <= lb_b[lb_idx];
            lb_b[lb_idx] <= pix_data;
        end
    end

    kp_fifo #(
        .DEPTH (KP_DEPTH),
        .WIDTH ($bits(kp_rec_t))
    ) u_kp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_rec),
        .pop       (pop),
        .pop_data  (head_rec),
        .count     (kp_count)
    );

endmodule

// File: tb/tb_fast_scan_ctrl.sv
// Scoreboard bench for fast_scan_ctrl on 8x8 frames with a behavioural corner
// filter and a frame-level reference model of expected keypoint coordinates.
module tb_fast_scan_ctrl;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int D  = 4;
    localparam int XW = 10;
    localparam int YW = 9;

    typedef struct {int x; int y;} exp_t;

    logic          clk = 1'b0;
    logic          rst_n, start, pix_valid, pix_ready, valid_keypoint;
    logic          kp_valid, kp_ready, busy, done;
    logic [7:0]    pix_data;
    logic [23:0]   fi0, fi1, fi2;
    logic [XW-1:0] kp_x;
    logic [YW-1:0] kp_y;

    exp_t exp_q[$];
    int   img[H][W];
    int   fp[9];
    int   tests = 0, fails = 0;
    int   cyc = 0, done_cnt = 0, pop_cnt = 0, rise_cyc = 0, acc55 = -1, n_exp = 0;
    bit   kp_prev = 1'b0;

    fast_scan_ctrl #(.IMG_W(W), .IMG_H(H), .X_W(XW), .Y_W(YW), .KP_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pix_ready),
        .filter_input_0(fi0), .filter_input_1(fi1), .filter_input_2(fi2),
        .valid_keypoint(valid_keypoint), .kp_valid(kp_valid), .kp_x(kp_x),
        .kp_y(kp_y), .kp_ready(kp_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Corner rule: centre p[4] differs from all 8 neighbours by more than 7, same sign.
    function automatic bit is_corner(input int p[9]);
        bit dk = 1'b1, br = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i != 4) begin
                if (!(p[i] - p[4] > 7)) dk = 1'b0;
                if (!(p[4] - p[i] > 7)) br = 1'b0;
            end
        end
        return dk || br;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            fp[i]     = int'(fi0[8*i +: 8]);
            fp[3 + i] = int'(fi1[8*i +: 8]);
            fp[6 + i] = int'(fi2[8*i +: 8]);
        end
        valid_keypoint = is_corner(fp);
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Interior pixels only, in raster order.
    task automatic ref_model();
        int p[9];
        n_exp = 0;
        for (int yy = 1; yy < H - 1; yy++)
            for (int xx = 1; xx < W - 1; xx++) begin
                for (int k = 0; k < 9; k++) p[k] = img[yy - 1 + k / 3][xx - 1 + k % 3];
                if (is_corner(p)) begin
                    exp_q.push_back('{x: xx, y: yy});
                    n_exp++;
                end
            end
    endtask

    task automatic fill(input int v);
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) img[yy][xx] = v;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) done_cnt++;
            if (kp_valid && !kp_prev) rise_cyc = cyc;
            kp_prev = kp_valid;
            if (kp_valid && kp_ready) begin
                pop_cnt++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL kp_unexpected: got x=%0d y=%0d expected none", kp_x, kp_y);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(kp_x) != e.x || int'(kp_y) != e.y) begin
                        fails++;
                        $display("FAIL kp_coord: got x=%0d y=%0d expected x=%0d y=%0d",
                                 kp_x, kp_y, e.x, e.y);
                    end
                end
            end else if (!kp_valid) begin
                tests++;
                if (kp_x != '0 || kp_y != '0) begin
                    fails++;
                    $display("FAIL kp_zero_when_empty: got x=%0d y=%0d expected 0 0", kp_x, kp_y);
                end
            end
        end
    end

    // start_at >= 0 pulses start alongside that pixel (must be ignored in SCAN).
    task automatic send_pixels(input int n, input int gap, input int start_at);
        for (int i = 0; i < n; i++) begin
            int px = i % W;
            int py = i / W;
            int waited = 0;
            bit got = 1'b0;
            if (gap > 0)
                while ($urandom_range(99) < gap) begin
                    pix_valid = 1'b0;
                    @(posedge clk); #1;
                end
            pix_valid = 1'b1;
            pix_data  = 8'(img[py][px]);
            if (i == start_at) start = 1'b1;
            while (!got && waited < 2000) begin
                @(negedge clk);
                if (pix_ready) begin
                    got = 1'b1;
                    if (px == 5 && py == 5) acc55 = cyc;
                end
                @(posedge clk); #1;
                start = 1'b0;
                waited++;
            end
            if (!got) begin
                check("pix_accept_timeout", 0, 1);
                pix_valid = 1'b0;
                return;
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic run_frame(input int gap, input int start_at);
        int d0, p0, n;
        exp_q.delete();
        ref_model();
        d0 = done_cnt;
        p0 = pop_cnt;
        pulse_start();
        send_pixels(W * H, gap, start_at);
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            check("done_timeout", 0, 1);
        end else begin
            check("busy_at_done", int'(busy), 1);
            @(negedge clk);
            check("done_one_cycle", int'(done), 0);
            check("busy_after_done", int'(busy), 0);
        end
        repeat (5) @(negedge clk);
        check("done_pulses", done_cnt - d0, 1);
        check("kp_count", pop_cnt - p0, n_exp);
        check("kp_all_popped", exp_q.size(), 0);
    endtask

    task automatic two_kp_frame();
        fill(50);
        img[2][2] = 20;
        img[4][5] = 20;
    endtask

    initial begin
        #2_000_000;
        fails++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = 8'd0; kp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_ready", int'(pix_ready), 0);
        check("rst_kp_valid", int'(kp_valid), 0);
        check("rst_kp_xy", int'(kp_x) + int'(kp_y), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_filter_in", int'(fi0 | fi1 | fi2), 0);
        @(negedge clk) rst_n = 1'b1;

        // Flat frame: no keypoints.
        fill(100);
        run_frame(0, -1);

        // Single dark dot at (4,4) with latency check.
        fill(50);
        img[4][4] = 20;
        run_frame(0, -1);
        check("kp_latency", rise_cyc - acc55, 2);

        // Corner pixels only: border masking.
        fill(50);
        img[0][0] = 200;
        img[7][7] = 200;
        run_frame(0, -1);

        // Nine dots with consumer stalled: backpressure and no loss.
        fill(50);
        for (int yy = 1; yy <= 5; yy += 2)
            for (int xx = 1; xx <= 5; xx += 2) img[yy][xx] = 20;
        kp_ready = 1'b0;
        fork
            run_frame(0, -1);
            begin
                repeat (200) @(posedge clk);
                @(negedge clk);
                check("pix_ready_backpressure", int'(pix_ready), 0);
                check("kp_valid_stalled", int'(kp_valid), 1);
                kp_ready = 1'b1;
            end
        join

        // Two-keypoint frame with 50% valid gaps.
        two_kp_frame();
        run_frame(50, -1);

        // Reset mid-scan on row 3, with an ignored start during SCAN.
        fill(80);
        exp_q.delete();
        pulse_start();
        send_pixels(3 * W + 3, 0, 10);
        check("busy_midscan", int'(busy), 1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_kp_valid", int'(kp_valid), 0);
        check("rst_mid_done", int'(done), 0);
        check("rst_mid_pix_ready", int'(pix_ready), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        two_kp_frame();
        run_frame(0, 20);

        // Random frames with random gaps.
        for (int r = 0; r < 3; r++) begin
            for (int yy = 0; yy < H; yy++)
                for (int xx = 0; xx < W; xx++) img[yy][xx] = 40 * $urandom_range(0, 3);
            run_frame($urandom_range(0, 50), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
